alu_sequencer: RTL and testbench

ALU_SEQUENCER -- requirements
Module: alu_sequencer

---
 rtl/alu_sequencer.sv | 164 ++++++++++++++++
 tb/tb_alu_sequencer.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/alu_sequencer.sv
// Sequences single ALU commands: register the operands, wait for the external ALU to settle,
// capture the result into a first-word-fall-through response buffer and keep a running accumulator.
module alu_sequencer #(
  parameter int SETTLE_CYCLES = 2,
  parameter int FIFO_DEPTH    = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [3:0]  cmd_opcode,
  input  logic [15:0] cmd_operand_a,
  input  logic [15:0] cmd_operand_b,
  input  logic        cmd_use_acc,
  output logic [15:0] alu_input1,
  output logic [15:0] alu_input2,
  output logic [3:0]  alu_opcode,
  input  logic [31:0] alu_result,
  input  logic [1:0]  alu_error,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_result,
  output logic [1:0]  rsp_error,
  output logic [31:0] acc,
  output logic        busy
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = (SETTLE_CYCLES > 2) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [CW-1:0] SETTLE_LOAD = CW'((SETTLE_CYCLES > 1) ? SETTLE_CYCLES - 2 : 0);
  localparam logic [AW:0]   DEPTH_C     = (AW + 1)'(FIFO_DEPTH);

  // CAPTURE is the last settle cycle; SETTLE covers the ones before it.
  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_SETTLE  = 2'd1;
  localparam logic [1:0] ST_CAPTURE = 2'd2;

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [15:0]   alu_in1_q, alu_in1_d;
  logic [15:0]   alu_in2_q, alu_in2_d;
  logic [3:0]    alu_op_q, alu_op_d;
  logic [31:0]   acc_q, acc_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic [33:0]   fifo_mem_q [FIFO_DEPTH];

  logic        accept;
  logic        push;
  logic        pop;
  logic [33:0] entry;

  // Response entry is {result, error}; opcodes outside the ALU set are flagged with 2'b11.
  function automatic logic [33:0] capture_entry(input logic [3:0]  op,
                                                input logic [31:0] res,
                                                input logic [1:0]  err);
    if (op == 4'd0)
      return 34'd0;
    else if (op <= 4'd5)
      return {res, err};
    else
      return {res, 2'b11};
  endfunction

  function automatic logic [31:0] next_acc(input logic [3:0]  op,
                                           input logic [31:0] res,
                                           input logic [1:0]  err,
                                           input logic [31:0] cur);
    if (op == 4'd0)
      return 32'd0;
    else if (op <= 4'd5 && err == 2'b00)
      return res;
    else
      return cur;
  endfunction

  assign cmd_ready  = !rst && (state_q == ST_IDLE) && (count_q < DEPTH_C);
  assign rsp_valid  = !rst && (count_q != '0);
  assign accept     = cmd_valid && cmd_ready;
  assign pop        = rsp_valid && rsp_ready;
  assign entry      = capture_entry(alu_op_q, alu_result, alu_error);
  assign rsp_result = fifo_mem_q[rd_ptr_q][33:2];
  assign rsp_error  = fifo_mem_q[rd_ptr_q][1:0];
  assign alu_input1 = alu_in1_q;
  assign alu_input2 = alu_in2_q;
  assign alu_opcode = alu_op_q;
  assign acc        = acc_q;
  assign busy       = (state_q != ST_IDLE);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    alu_in1_d = alu_in1_q;
    alu_in2_d = alu_in2_q;
    alu_op_d  = alu_op_q;
    acc_d     = acc_q;
    push      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          alu_in1_d = cmd_use_acc ? acc_q[15:0] : cmd_operand_a;
          alu_in2_d = cmd_operand_b;
          alu_op_d  = cmd_opcode;
          cnt_d     = SETTLE_LOAD;
          state_d   = (SETTLE_CYCLES > 1) ? ST_SETTLE : ST_CAPTURE;
        end
      end
      ST_SETTLE: begin
        if (cnt_q == '0)
          state_d = ST_CAPTURE;
        else
          cnt_d = cnt_q - 1'b1;
      end
      ST_CAPTURE: begin
        push    = 1'b1;
        acc_d   = next_acc(alu_op_q, alu_result, alu_error, acc_q);
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Pointers wrap naturally because the depth is a power of two.
  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d  = count_q;
    if (push && !pop)
      count_d = count_q + 1'b1;
    else if (pop && !push)
      count_d = count_q - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      alu_in1_q <= '0;
      alu_in2_q <= '0;
      alu_op_q  <= '0;
      acc_q     <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      alu_in1_q <= alu_in1_d;
      alu_in2_q <= alu_in2_d;
      alu_op_q  <= alu_op_d;
      acc_q     <= acc_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !rst)
      fifo_mem_q[wr_ptr_q] <= entry;
  end

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer with a behavioural ALU model driving alu_result/alu_error.
module tb_alu_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [3:0]  cmd_opcode;
  logic [15:0] cmd_operand_a;
  logic [15:0] cmd_operand_b;
  logic        cmd_use_acc;
  logic [15:0] alu_input1;
  logic [15:0] alu_input2;
  logic [3:0]  alu_opcode;
  logic [31:0] alu_result;
  logic [1:0]  alu_error;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_result;
  logic [1:0]  rsp_error;
  logic [31:0] acc;
  logic        busy;

  int checks   = 0;
  int failures = 0;

  alu_sequencer #(.SETTLE_CYCLES(2), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_opcode(cmd_opcode),
    .cmd_operand_a(cmd_operand_a), .cmd_operand_b(cmd_operand_b), .cmd_use_acc(cmd_use_acc),
    .alu_input1(alu_input1), .alu_input2(alu_input2), .alu_opcode(alu_opcode),
    .alu_result(alu_result), .alu_error(alu_error),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result), .rsp_error(rsp_error),
    .acc(acc), .busy(busy)
  );

  always #5 clk = ~clk;

  always_comb begin
    alu_result = 32'd0;
    alu_error  = 2'b00;
    case (alu_opcode)
      4'd0: alu_result = 32'd0;
      4'd1: alu_result = {16'd0, alu_input1} + {16'd0, alu_input2};
      4'd2: alu_result = {16'd0, alu_input1} - {16'd0, alu_input2};
      4'd3: alu_result = {16'd0, alu_input1} * {16'd0, alu_input2};
      4'd4: if (alu_input2 == 16'd0) alu_error = 2'b10;
            else alu_result = {16'd0, alu_input1 / alu_input2};
      4'd5: if (alu_input2 == 16'd0) alu_error = 2'b10;
            else alu_result = {16'd0, alu_input1 % alu_input2};
      default: alu_result = 32'hA5A5_0000 | {28'd0, alu_opcode};
    endcase
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Starts at a negedge, ends at the negedge after the accept edge.
  task automatic send(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                      input logic use_acc);
    int n;
    cmd_opcode    = op;
    cmd_operand_a = a;
    cmd_operand_b = b;
    cmd_use_acc   = use_acc;
    cmd_valid     = 1'b1;
    n = 0;
    while (!cmd_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) chk("accept_timeout", {31'd0, cmd_ready}, 32'd1);
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  // Ends at the negedge after the capture edge.
  task automatic run(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                     input logic use_acc);
    send(op, a, b, use_acc);
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic pop_chk(input string tag, input logic [31:0] exp_res, input logic [1:0] exp_err);
    chk({tag, "_valid"}, {31'd0, rsp_valid}, 32'd1);
    chk({tag, "_result"}, rsp_result, exp_res);
    chk({tag, "_error"}, {30'd0, rsp_error}, {30'd0, exp_err});
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  initial begin
    rst = 1'b1; cmd_valid = 1'b0; cmd_opcode = '0; cmd_operand_a = '0;
    cmd_operand_b = '0; cmd_use_acc = 1'b0; rsp_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_cmd_ready", {31'd0, cmd_ready}, 32'd0);
    chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_acc", acc, 32'd0);
    chk("rst_alu_in1", {16'd0, alu_input1}, 32'd0);
    chk("rst_alu_op", {28'd0, alu_opcode}, 32'd0);
    rst = 1'b0;
    #1;
    chk("post_rst_ready", {31'd0, cmd_ready}, 32'd1);

    // add 3+1 with exact response latency
    send(4'd1, 16'd3, 16'd1, 1'b0);
    chk("t1_alu_in1", {16'd0, alu_input1}, 32'd3);
    chk("t1_alu_in2", {16'd0, alu_input2}, 32'd1);
    chk("t1_alu_op", {28'd0, alu_opcode}, 32'd1);
    chk("t1_busy_e0", {31'd0, busy}, 32'd1);
    chk("t1_ready_e0", {31'd0, cmd_ready}, 32'd0);
    chk("t1_valid_e0", {31'd0, rsp_valid}, 32'd0);
    @(negedge clk);
    chk("t1_valid_e1", {31'd0, rsp_valid}, 32'd0);
    chk("t1_busy_e1", {31'd0, busy}, 32'd1);
    @(negedge clk);
    chk("t1_valid_e2", {31'd0, rsp_valid}, 32'd1);
    chk("t1_busy_e2", {31'd0, busy}, 32'd0);
    chk("t1_acc", acc, 32'h4);
    chk("t1_ready_e2", {31'd0, cmd_ready}, 32'd1);
    pop_chk("t1", 32'h4, 2'b00);
    chk("t1_empty", {31'd0, rsp_valid}, 32'd0);

    // chained multiply from the accumulator
    send(4'd3, 16'hFFFF, 16'd5, 1'b1);
    chk("t2_alu_in1", {16'd0, alu_input1}, 32'h4);
    @(negedge clk);
    @(negedge clk);
    pop_chk("t2", 32'h14, 2'b00);
    chk("t2_acc", acc, 32'h14);

    // divide by zero, unknown opcode, empty pop, clear
    run(4'd4, 16'd7, 16'd0, 1'b0);
    pop_chk("t3_div0", 32'h0, 2'b10);
    chk("t3_div0_acc", acc, 32'h14);
    run(4'd9, 16'd1, 16'd2, 1'b0);
    pop_chk("t3_op9", 32'hA5A5_0009, 2'b11);
    chk("t3_op9_acc", acc, 32'h14);
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    chk("t3_empty_pop", {31'd0, rsp_valid}, 32'd0);
    run(4'd0, 16'd0, 16'd0, 1'b0);
    chk("t3_clear_acc", acc, 32'd0);
    pop_chk("t3_clear", 32'h0, 2'b00);

    // backpressure: fill four entries, fifth waits for space
    for (int i = 0; i < 4; i++) run(4'd1, 16'(10 + i), 16'(i), 1'b0);
    chk("t4_full_ready", {31'd0, cmd_ready}, 32'd0);
    chk("t4_full_valid", {31'd0, rsp_valid}, 32'd1);
    cmd_opcode = 4'd1; cmd_operand_a = 16'd14; cmd_operand_b = 16'd4; cmd_use_acc = 1'b0;
    cmd_valid = 1'b1;
    repeat (3) @(negedge clk);
    chk("t4_blocked_busy", {31'd0, busy}, 32'd0);
    chk("t4_blocked_ready", {31'd0, cmd_ready}, 32'd0);
    chk("t4_head0", rsp_result, 32'd10);
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("t4_head1", rsp_result, 32'd12);
    chk("t4_ready_freed", {31'd0, cmd_ready}, 32'd1);
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("t4_fifth_busy", {31'd0, busy}, 32'd1);
    chk("t4_head2", rsp_result, 32'd14);
    @(negedge clk);
    chk("t4_head3", rsp_result, 32'd16);
    @(negedge clk);
    chk("t4_head4", rsp_result, 32'd18);
    chk("t4_acc", acc, 32'd18);
    @(negedge clk);
    rsp_ready = 1'b0;
    chk("t4_drained", {31'd0, rsp_valid}, 32'd0);

    // simultaneous push and pop with three entries held
    run(4'd1, 16'd1, 16'd0, 1'b0);
    run(4'd1, 16'd2, 16'd0, 1'b0);
    run(4'd1, 16'd3, 16'd0, 1'b0);
    send(4'd1, 16'd4, 16'd0, 1'b0);
    @(negedge clk);
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    chk("t5_ready_count3", {31'd0, cmd_ready}, 32'd1);
    chk("t5_acc", acc, 32'd4);
    pop_chk("t5_a", 32'd2, 2'b00);
    pop_chk("t5_b", 32'd3, 2'b00);
    pop_chk("t5_c", 32'd4, 2'b00);
    chk("t5_empty", {31'd0, rsp_valid}, 32'd0);

    // reset while a command is settling
    send(4'd1, 16'd5, 16'd5, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("t6_busy", {31'd0, busy}, 32'd0);
    chk("t6_acc", acc, 32'd0);
    chk("t6_ready", {31'd0, cmd_ready}, 32'd1);
    chk("t6_alu_in1", {16'd0, alu_input1}, 32'd0);
    repeat (3) @(negedge clk);
    chk("t6_no_rsp", {31'd0, rsp_valid}, 32'd0);
    run(4'd1, 16'd2, 16'd2, 1'b0);
    pop_chk("t6_after", 32'd4, 2'b00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
